// File: rtl/mux_nx1_stream.sv
// N-channel, W-bit valid/ready stream multiplexer with a one-word registered output stage.
// Define MUX_NX1_STREAM_RR_EN to build the round-robin arbiter selected by the mode input.
module mux_nx1_stream #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 16,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   grant,
    output logic [CW-1:0]   xfer_count
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   data_q, data_d;
    logic [SW-1:0]  grant_q, grant_d;
    logic [CW-1:0]  count_q, count_d;

    logic           pipe_en;
    logic           ch_ok;
    logic [SW-1:0]  ch;
    logic [W-1:0]   ch_data;
    logic           ch_valid;
    logic           accept;

    assign pipe_en = (state_q == StEmpty) || out_ready;

`ifdef MUX_NX1_STREAM_RR_EN
    logic [SW-1:0]  ptr_q, ptr_d;
    logic           hi_ok, lo_ok;
    logic [SW-1:0]  hi_ch, lo_ch;

    // Descending scan leaves the lowest valid index in each half; the half at/after ptr wins.
    always_comb begin
        hi_ok = 1'b0;
        lo_ok = 1'b0;
        hi_ch = '0;
        lo_ch = '0;
        for (int c = N - 1; c >= 0; c--) begin
            if (in_valid[c]) begin
                if (SW'(c) >= ptr_q) begin
                    hi_ok = 1'b1;
                    hi_ch = SW'(c);
                end else begin
                    lo_ok = 1'b1;
                    lo_ch = SW'(c);
                end
            end
        end
    end

    always_comb begin
        if (mode) begin
            ch    = hi_ok ? hi_ch : lo_ch;
            ch_ok = hi_ok || lo_ok;
        end else begin
            ch    = sel;
            ch_ok = 32'(sel) < N;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && mode) begin
            ptr_d = (32'(ch) == N - 1) ? '0 : ch + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign ch          = sel;
    assign ch_ok       = 32'(sel) < N;
`endif

    always_comb begin
        in_ready = '0;
        ch_data  = '0;
        ch_valid = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (ch_ok && (ch == SW'(c))) begin
                ch_data     = in_data[c*W +: W];
                ch_valid    = in_valid[c];
                in_ready[c] = pipe_en && !rst;
            end
        end
    end

    assign accept = pipe_en && ch_valid;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        count_d = count_q;
        if (pipe_en) begin
            if (accept) begin
                state_d = StFull;
                data_d  = ch_data;
                grant_d = ch;
                count_d = count_q + CW'(1);
            end else begin
                state_d = StEmpty;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            data_q  <= '0;
            grant_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            count_q <= count_d;
        end
    end

    assign out_valid  = (state_q == StFull);
    assign out_data   = data_q;
    assign grant      = grant_q;
    assign xfer_count = count_q;

endmodule
